// File: rtl/cci_tracker_pkg.sv
// Shared field layout, widths and hazard classification for the CCI hazard tracker.
package cci_tracker_pkg;

    localparam int CLADDR_WIDTH = 32;
    localparam int MDATA_WIDTH  = 14;

    localparam int MDATA_LSB  = 0;
    localparam int MDATA_MSB  = 13;
    localparam int CLADDR_LSB = 14;
    localparam int CLADDR_MSB = 45;

    typedef enum logic [1:0] {
        HAZ_NONE = 2'd0,
        HAZ_RAW  = 2'd1,
        HAZ_WAR  = 2'd2,
        HAZ_WAW  = 2'd3
    } hazard_kind_e;

endpackage

// File: rtl/cci_hazard_tracker_if.sv
// Request/response and status bundle between the CCI monitor point and the tracker.
interface cci_hazard_tracker_if
    import cci_tracker_pkg::*;
#(
    parameter int TX_HDR_WIDTH = 61,
    parameter int RX_HDR_WIDTH = 18,
    parameter int NUM_ENTRIES  = 16
);
    localparam int OUT_W = $clog2(NUM_ENTRIES + 1);

    logic                    lp_initdone;
    logic [TX_HDR_WIDTH-1:0] tx_c0_header;
    logic [TX_HDR_WIDTH-1:0] tx_c1_header;
    logic                    tx_c0_rdvalid;
    logic                    tx_c1_wrvalid;
    logic [RX_HDR_WIDTH-1:0] rx_c0_header;
    logic [RX_HDR_WIDTH-1:0] rx_c1_header;
    logic                    rx_c0_rdvalid;
    logic                    rx_c0_wrvalid;
    logic                    rx_c1_wrvalid;

    logic                    hazard_valid;
    hazard_kind_e            hazard_kind;
    logic [CLADDR_WIDTH-1:0] hazard_claddr;
    logic [31:0]             hazard_count;
    logic [OUT_W-1:0]        outstanding;
    logic                    overflow;
    logic [31:0]             overflow_count;
    logic                    timeout_valid;
    logic [MDATA_WIDTH-1:0]  timeout_mdata;
    logic                    orphan_valid;
    logic [MDATA_WIDTH-1:0]  orphan_mdata;

    modport master (
        output lp_initdone, tx_c0_header, tx_c1_header, tx_c0_rdvalid, tx_c1_wrvalid,
               rx_c0_header, rx_c1_header, rx_c0_rdvalid, rx_c0_wrvalid, rx_c1_wrvalid,
        input  hazard_valid, hazard_kind, hazard_claddr, hazard_count, outstanding,
               overflow, overflow_count, timeout_valid, timeout_mdata, orphan_valid, orphan_mdata
    );

    modport slave (
        input  lp_initdone, tx_c0_header, tx_c1_header, tx_c0_rdvalid, tx_c1_wrvalid,
               rx_c0_header, rx_c1_header, rx_c0_rdvalid, rx_c0_wrvalid, rx_c1_wrvalid,
        output hazard_valid, hazard_kind, hazard_claddr, hazard_count, outstanding,
               overflow, overflow_count, timeout_valid, timeout_mdata, orphan_valid, orphan_mdata
    );

endinterface

// File: rtl/cci_track_entry.sv
// One outstanding-request slot: payload, watchdog age and the address/mdata comparators.
module cci_track_entry
    import cci_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    alloc,
    input  logic                    alloc_is_write,
    input  logic [CLADDR_WIDTH-1:0] alloc_claddr,
    input  logic [MDATA_WIDTH-1:0]  alloc_mdata,
    input  logic                    free,
    input  logic                    timeout_ack,
    input  logic [CLADDR_WIDTH-1:0] c0_claddr,
    input  logic [CLADDR_WIDTH-1:0] c1_claddr,
    input  logic [MDATA_WIDTH-1:0]  rx0_mdata,
    input  logic [MDATA_WIDTH-1:0]  rx1_mdata,
    output logic                    valid,
    output logic                    is_write,
    output logic [MDATA_WIDTH-1:0]  mdata,
    output logic                    c0_hit,
    output logic                    c1_hit,
    output logic                    rd_hit,
    output logic                    wr0_hit,
    output logic                    wr1_hit,
    output logic                    timeout_pending
);
    localparam int              AGE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

    logic [CLADDR_WIDTH-1:0] claddr;
    logic [AGE_W-1:0]        age;
    logic                    reported;

    // NOTE: only the control bits are reset; the payload is qualified by valid and is left unreset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            valid    <= 1'b0;
            age      <= '0;
            reported <= 1'b0;
        end else if (alloc) begin
            valid    <= 1'b1;
            is_write <= alloc_is_write;
            claddr   <= alloc_claddr;
            mdata    <= alloc_mdata;
            age      <= '0;
            reported <= 1'b0;
        end else begin
            if (free)                     valid    <= 1'b0;
            if (valid && age != AGE_MAX)  age      <= age + 1'b1;
            if (timeout_ack)              reported <= 1'b1;
        end
    end

    assign c0_hit          = valid && (claddr == c0_claddr);
    assign c1_hit          = valid && (claddr == c1_claddr);
    assign rd_hit          = valid && !is_write && (mdata == rx0_mdata);
    assign wr0_hit         = valid &&  is_write && (mdata == rx0_mdata);
    assign wr1_hit         = valid &&  is_write && (mdata == rx1_mdata);
    assign timeout_pending = valid && (age == AGE_MAX) && !reported;

endmodule

// File: rtl/cci_hazard_tracker.sv
// Tracks outstanding CCI reads/writes, flags address hazards, orphans, overflow and response timeouts.
module cci_hazard_tracker
    import cci_tracker_pkg::*;
#(
    parameter int TX_HDR_WIDTH   = 61,
    parameter int RX_HDR_WIDTH   = 18,
    parameter int NUM_ENTRIES    = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 resetb,
    cci_hazard_tracker_if.slave  bus
);
    localparam int OUT_W = $clog2(NUM_ENTRIES + 1);
    typedef logic [NUM_ENTRIES-1:0] vec_t;

    function automatic vec_t lowest(input vec_t v);
        return v & (~v + NUM_ENTRIES'(1));
    endfunction

    logic [CLADDR_WIDTH-1:0] c0_claddr, c1_claddr;
    logic [MDATA_WIDTH-1:0]  c0_mdata, c1_mdata, rx0_mdata, rx1_mdata;
    logic                    c0_req, c1_req, rx_rd, rx_wr0, rx_wr1;
    logic                    unused_hdr_bits;

    assign c0_claddr = bus.tx_c0_header[CLADDR_MSB:CLADDR_LSB];
    assign c1_claddr = bus.tx_c1_header[CLADDR_MSB:CLADDR_LSB];
    assign c0_mdata  = bus.tx_c0_header[MDATA_MSB:MDATA_LSB];
    assign c1_mdata  = bus.tx_c1_header[MDATA_MSB:MDATA_LSB];
    assign rx0_mdata = bus.rx_c0_header[MDATA_MSB:MDATA_LSB];
    assign rx1_mdata = bus.rx_c1_header[MDATA_MSB:MDATA_LSB];
    assign unused_hdr_bits = ^{bus.tx_c0_header[TX_HDR_WIDTH-1:CLADDR_MSB+1],
                               bus.tx_c1_header[TX_HDR_WIDTH-1:CLADDR_MSB+1],
                               bus.rx_c0_header[RX_HDR_WIDTH-1:MDATA_MSB+1],
                               bus.rx_c1_header[RX_HDR_WIDTH-1:MDATA_MSB+1]};

    assign c0_req = bus.lp_initdone && bus.tx_c0_rdvalid;
    assign c1_req = bus.lp_initdone && bus.tx_c1_wrvalid;
    assign rx_rd  = bus.lp_initdone && bus.rx_c0_rdvalid;
    assign rx_wr0 = bus.lp_initdone && bus.rx_c0_wrvalid;
    assign rx_wr1 = bus.lp_initdone && bus.rx_c1_wrvalid;

    vec_t valid_v, is_write_v, c0_hit_v, c1_hit_v, rd_hit_v, wr0_hit_v, wr1_hit_v, pending_v;
    vec_t c0_alloc_v, c1_alloc_v, rd_free_v, wr0_free_v, wr1_free_v, free_v, ack_v, next_valid;
    logic [MDATA_WIDTH-1:0] entry_mdata [NUM_ENTRIES];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        cci_track_entry #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_entry (
            .clk             (clk),
            .resetb          (resetb),
            .alloc           (c0_alloc_v[i] | c1_alloc_v[i]),
            .alloc_is_write  (c1_alloc_v[i]),
            .alloc_claddr    (c1_alloc_v[i] ? c1_claddr : c0_claddr),
            .alloc_mdata     (c1_alloc_v[i] ? c1_mdata : c0_mdata),
            .free            (free_v[i]),
            .timeout_ack     (ack_v[i]),
            .c0_claddr       (c0_claddr),
            .c1_claddr       (c1_claddr),
            .rx0_mdata       (rx0_mdata),
            .rx1_mdata       (rx1_mdata),
            .valid           (valid_v[i]),
            .is_write        (is_write_v[i]),
            .mdata           (entry_mdata[i]),
            .c0_hit          (c0_hit_v[i]),
            .c1_hit          (c1_hit_v[i]),
            .rd_hit          (rd_hit_v[i]),
            .wr0_hit         (wr0_hit_v[i]),
            .wr1_hit         (wr1_hit_v[i]),
            .timeout_pending (pending_v[i])
        );
    end

    logic                   c0_haz, c1_haz, c1_waw, c0_orph, c1_orph, c0_ovf, c1_ovf;
    logic [OUT_W-1:0]       outstanding_n;
    logic [MDATA_WIDTH-1:0] to_mdata_n;
    logic [32:0]            hz_sum;

    // NOTE: always_comb uses blocking assignments with every output defaulted first, so no latch can form.
    always_comb begin
        c0_alloc_v = c0_req ? lowest(~valid_v) : '0;
        c1_alloc_v = c1_req ? lowest(~valid_v & ~c0_alloc_v) : '0;
        rd_free_v  = rx_rd  ? lowest(rd_hit_v)  : '0;
        wr0_free_v = rx_wr0 ? lowest(wr0_hit_v) : '0;
        wr1_free_v = rx_wr1 ? lowest(wr1_hit_v & ~wr0_free_v) : '0;
        free_v     = rd_free_v | wr0_free_v | wr1_free_v;
        ack_v      = lowest(pending_v);
        next_valid = (valid_v & ~free_v) | c0_alloc_v | c1_alloc_v;

        outstanding_n = '0;
        to_mdata_n    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            outstanding_n = outstanding_n + OUT_W'(next_valid[i]);
            if (ack_v[i]) to_mdata_n = to_mdata_n | entry_mdata[i];
        end

        // c0 is the older request, so a same-cycle c1 write to its line is a WAR.
        c0_haz = c0_req && |(c0_hit_v & is_write_v);
        c1_waw = |(c1_hit_v & is_write_v);
        c1_haz = c1_req && (c1_waw || |(c1_hit_v & ~is_write_v) || (c0_req && c0_claddr == c1_claddr));

        c0_orph = (rx_rd && !(|rd_hit_v)) || (rx_wr0 && !(|wr0_hit_v));
        c1_orph = rx_wr1 && !(|(wr1_hit_v & ~wr0_free_v));
        c0_ovf  = c0_req && !(|c0_alloc_v);
        c1_ovf  = c1_req && !(|c1_alloc_v);
    end

    logic                    hz_valid_s, ovf_s, to_valid_s, orph_valid_s;
    hazard_kind_e            hz_kind_s;
    logic [CLADDR_WIDTH-1:0] hz_claddr_s;
    logic [31:0]             hz_count_s, ovf_count_s;
    logic [OUT_W-1:0]        outstanding_s;
    logic [MDATA_WIDTH-1:0]  to_mdata_s, orph_mdata_s;

    assign hz_sum = {1'b0, hz_count_s} + 33'(c0_haz) + 33'(c1_haz);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            hz_valid_s    <= 1'b0;
            hz_kind_s     <= HAZ_NONE;
            hz_claddr_s   <= '0;
            hz_count_s    <= '0;
            ovf_s         <= 1'b0;
            ovf_count_s   <= '0;
            outstanding_s <= '0;
            to_valid_s    <= 1'b0;
            to_mdata_s    <= '0;
            orph_valid_s  <= 1'b0;
            orph_mdata_s  <= '0;
        end else begin
            hz_valid_s    <= c0_haz || c1_haz;
            hz_kind_s     <= c0_haz ? HAZ_RAW : (c1_haz ? (c1_waw ? HAZ_WAW : HAZ_WAR) : HAZ_NONE);
            hz_claddr_s   <= c0_haz ? c0_claddr : (c1_haz ? c1_claddr : '0);
            hz_count_s    <= hz_sum[32] ? '1 : hz_sum[31:0];
            ovf_s         <= ovf_s || c0_ovf || c1_ovf;
            ovf_count_s   <= ovf_count_s + 32'(c0_ovf) + 32'(c1_ovf);
            outstanding_s <= outstanding_n;
            to_valid_s    <= |ack_v;
            to_mdata_s    <= to_mdata_n;
            orph_valid_s  <= c0_orph || c1_orph;
            orph_mdata_s  <= c0_orph ? rx0_mdata : (c1_orph ? rx1_mdata : '0);
        end
    end

    // Output stage: results of the edge that sampled the inputs appear after the following edge.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            bus.hazard_valid   <= 1'b0;
            bus.hazard_kind    <= HAZ_NONE;
            bus.hazard_claddr  <= '0;
            bus.hazard_count   <= '0;
            bus.overflow       <= 1'b0;
            bus.overflow_count <= '0;
            bus.outstanding    <= '0;
            bus.timeout_valid  <= 1'b0;
            bus.timeout_mdata  <= '0;
            bus.orphan_valid   <= 1'b0;
            bus.orphan_mdata   <= '0;
        end else begin
            bus.hazard_valid   <= hz_valid_s;
            bus.hazard_kind    <= hz_kind_s;
            bus.hazard_claddr  <= hz_claddr_s;
            bus.hazard_count   <= hz_count_s;
            bus.overflow       <= ovf_s;
            bus.overflow_count <= ovf_count_s;
            bus.outstanding    <= outstanding_s;
            bus.timeout_valid  <= to_valid_s;
            bus.timeout_mdata  <= to_mdata_s;
            bus.orphan_valid   <= orph_valid_s;
            bus.orphan_mdata   <= orph_mdata_s;
        end
    end

endmodule

// File: doc/cci_hazard_tracker.md
CCI_HAZARD_TRACKER -- requirements
Module: cci_hazard_tracker

Interface
REQ-001 SHALL have parameter TX_HDR_WIDTH, default 61, TX header width.
REQ-002 SHALL have parameter RX_HDR_WIDTH, default 18, RX header width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 16, outstanding-request table depth (power of 2, 2..64).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, per-entry response watchdog limit.
REQ-005 SHALL have ports: clk  in  1  single clock; one clock, reset is synchronous and active-low.
REQ-006 SHALL have ports: resetb  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: lp_initdone  in  1  tracking enable; tx_c0_header/tx_c1_header  in  TX_HDR_WIDTH; tx_c0_rdvalid, tx_c1_wrvalid  in  1.
REQ-008 SHALL have ports: rx_c0_header, rx_c1_header  in  RX_HDR_WIDTH; rx_c0_rdvalid, rx_c0_wrvalid, rx_c1_wrvalid  in  1.
REQ-009 SHALL have outputs: hazard_valid 1 pulse; hazard_kind 2 (1=RAW, 2=WAR, 3=WAW); hazard_claddr CLADDR_WIDTH; hazard_count 32.
REQ-010 SHALL have outputs: outstanding clog2(NUM_ENTRIES+1) live entries; overflow 1 sticky; overflow_count 32.
REQ-011 SHALL have outputs: timeout_valid 1 pulse; timeout_mdata MDATA_WIDTH; orphan_valid 1 pulse; orphan_mdata MDATA_WIDTH.

Function
REQ-012 Entry SHALL hold valid, claddr, mdata, is_write, age counter, timeout_reported.
REQ-013 Requests/responses SHALL be sampled only when lp_initdone=1; otherwise ignored, table unchanged, ages still advance.
REQ-014 tx_c0_rdvalid SHALL allocate a read entry, tx_c1_wrvalid a write entry, both in one cycle allowed; c0 takes lowest free index, c1 next lowest.
REQ-015 Lookup SHALL compare new request claddr against entries valid before this edge: prior write+new read=RAW, prior read+new write=WAR, write+write=WAW, read+read=no hazard.
REQ-016 Same-cycle c0 and c1 to equal claddr SHALL report WAR (c0 is older).
REQ-017 Hazarding requests SHALL still allocate; hazard_count SHALL add number of hazards that cycle (0..2, saturating at 2^32-1).
REQ-018 Two hazards in one cycle: hazard_valid/kind/claddr SHALL report c0's; the other only counts.
REQ-019 rx_c0_rdvalid SHALL free lowest-index valid read entry with matching mdata; rx_c0_wrvalid and rx_c1_wrvalid each SHALL free lowest-index matching write entry; same-cycle both free distinct entries.
REQ-020 A response with no matching entry SHALL pulse orphan_valid with its mdata (c0 before c1 if both orphan).
REQ-021 Frees SHALL apply only to entries valid before the edge; a same-cycle allocation is never freed by a same-cycle response.
REQ-022 Request with no free entry SHALL not be tracked, SHALL set overflow (sticky until reset), SHALL increment overflow_count; hazard lookup still applies.
REQ-023 Age SHALL increment each cycle while valid, saturating at TIMEOUT_CYCLES; at reaching it timeout_reported set and timeout_valid pulses once with mdata, lowest index first if several; deferred ones report next cycles.
REQ-024 All outputs SHALL be registered; effects of inputs sampled at edge N visible after edge N+1 (1-cycle latency); outstanding reflects table after allocs/frees of edge N.
REQ-025 Field positions: TX mdata [13:0], TX claddr [45:14], RX mdata [13:0]; CLADDR_WIDTH=32, MDATA_WIDTH=14.

Reset
REQ-026 resetb=0 at posedge SHALL clear all entries, counters, overflow, and drive every output to 0, including mid-operation; inputs in that cycle ignored.
REQ-027 First cycle after resetb rises SHALL track normally.

Structure
REQ-028 Field-range constants, CLADDR_WIDTH, MDATA_WIDTH and hazard-kind enum SHALL live in shared package cci_tracker_pkg.
REQ-029 Per-entry storage, age counter and compare SHALL be sub-module cci_track_entry, instantiated NUM_ENTRIES times; free-index and priority pick SHALL stay in top.

Verification
REQ-030 c1 write claddr 0x100 mdata 5, next cycle c0 read 0x100 mdata 6 -> hazard_valid, kind=1, claddr 0x100, hazard_count=1, outstanding=2.
REQ-031 Same cycle c0 read and c1 write claddr 0x40 -> kind=2, hazard_count=1; two read-read to 0x40 later -> no hazard.
REQ-032 Fill 16 entries, 17th request -> overflow=1, overflow_count=1, outstanding=16; one rx response frees one, next request allocates, overflow stays 1.
REQ-033 rx_c0_rdvalid mdata 0x3FF with empty table -> orphan_valid, orphan_mdata 0x3FF, outstanding unchanged.
REQ-034 TIMEOUT_CYCLES=8, read mdata 9 with no response -> single timeout_valid pulse, mdata 9; later response frees it without orphan.
REQ-035 resetb=0 with 5 entries outstanding -> next cycle outstanding=0, overflow=0, counters 0.
